alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's combinational 32-bit add/sub/compare/rotate units. Accepts one operation per cycle on a valid/ready input port and returns a registered result with carry/zero/greater flags on a valid/ready output port. An optional iterative multiplier adds a multi-cycle path with its own busy state. Sits between the operand-fetch stage and writeback in the datapath.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_pipe_if.sv | 27 ++
 rtl/alu_mul_iter.sv | 55 +++++
 rtl/alu_pipe.sv | 149 ++++++++++++++
 tb/tb_alu_pipe.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for alu_pipe: opcodes, FSM states and the registered flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpCmp  = 3'd2,
        OpRotr = 3'd3,
        OpRotl = 3'd4,
        OpMul  = 3'd5
    } alu_op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic gt;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Valid/ready operation port and result port of alu_pipe.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_gt;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_zero, out_gt, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_zero, out_gt, out_err
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle; used only under ALU_PIPE_MUL_EN.
// done/product/overflow are valid combinationally during the final step.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             overflow
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q;
    logic               active_q;

    always_comb begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = active_q && (cnt_q == CW'(WIDTH - 1));
        product  = acc_d[WIDTH-1:0];
        overflow = |acc_d[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (done) begin
                active_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// Handshaked add/sub/compare/rotate unit with a registered result and flags.
// Define ALU_PIPE_MUL_EN to add the iterative multiplier (opcode 5) and its BUSY state.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    logic [WIDTH-1:0]   alu_res;
    alu_flags_t         alu_flags;
    logic [WIDTH:0]     sum;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] rot_r, rot_l;
    alu_op_e            op;

    alu_state_e         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   res_q, res_d;
    alu_flags_t         flags_q, flags_d;
    logic               accept;

`ifdef ALU_PIPE_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic               mul_ovf;
    logic [WIDTH-1:0]   mul_prod;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start),
        .a        (bus.in_a),
        .b        (bus.in_b),
        .done     (mul_done),
        .product  (mul_prod),
        .overflow (mul_ovf)
    );
`endif

    assign op           = alu_op_e'(bus.in_op);
    assign bus.in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);

    // Single-cycle datapath; rotates are taken from a doubled operand.
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        sum       = '0;
        sh        = bus.in_b[SHW-1:0];
        rot_r     = {bus.in_a, bus.in_a} >> sh;
        rot_l     = {bus.in_a, bus.in_a} << sh;
        case (op)
            OpAdd: begin
                sum             = {1'b0, bus.in_a} + {1'b0, bus.in_b};
                alu_res         = sum[WIDTH-1:0];
                alu_flags.carry = sum[WIDTH];
            end
            OpSub: begin
                sum             = {1'b0, bus.in_a} - {1'b0, bus.in_b};
                alu_res         = sum[WIDTH-1:0];
                alu_flags.carry = sum[WIDTH];
            end
            OpCmp: begin
                alu_flags.carry = bus.in_a < bus.in_b;
                alu_flags.gt    = bus.in_a > bus.in_b;
                alu_flags.zero  = bus.in_a == bus.in_b;
            end
            OpRotr:  alu_res = rot_r[WIDTH-1:0];
            OpRotl:  alu_res = rot_l[2*WIDTH-1:WIDTH];
`ifdef ALU_PIPE_MUL_EN
            OpMul:   alu_res = '0;
`endif
            default: alu_flags.err = 1'b1;
        endcase
        if (!alu_flags.err && op != OpCmp) begin
            alu_flags.zero = (alu_res == '0);
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        res_d       = res_q;
        flags_d     = flags_q;
        accept      = bus.in_valid && bus.in_ready;
`ifdef ALU_PIPE_MUL_EN
        mul_start   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef ALU_PIPE_MUL_EN
                    if (op == OpMul) begin
                        mul_start = 1'b1;
                        state_d   = StBusy;
                    end else begin
                        out_valid_d = 1'b1;
                        res_d       = alu_res;
                        flags_d     = alu_flags;
                    end
`else
                    out_valid_d = 1'b1;
                    res_d       = alu_res;
                    flags_d     = alu_flags;
`endif
                end
            end
`ifdef ALU_PIPE_MUL_EN
            StBusy: begin
                // out_valid is already clear here: a MUL is only accepted when the
                // previous result is drained on the same edge.
                if (mul_done) begin
                    out_valid_d   = 1'b1;
                    res_d         = mul_prod;
                    flags_d       = '0;
                    flags_d.carry = mul_ovf;
                    flags_d.zero  = (mul_prod == '0);
                    state_d       = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = res_q;
    assign bus.out_carry  = flags_q.carry;
    assign bus.out_zero   = flags_q.zero;
    assign bus.out_gt     = flags_q.gt;
    assign bus.out_err    = flags_q.err;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=32; MUL checks follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        g;
        logic        e;
    } exp_t;

    // Reference model from the operation rules, using 64-bit arithmetic and bitwise rotation loops.
    function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic [63:0] wide;
        int n;
        r = '0;
        n = int'(b % 32);
        case (op)
            0: begin
                wide  = 64'(a) + 64'(b);
                r.res = wide[31:0];
                r.c   = wide[32];
            end
            1: begin
                r.res = a - b;
                r.c   = (a < b);
            end
            2: begin
                r.c = (a < b);
                r.g = (a > b);
                r.z = (a == b);
            end
            3: begin
                r.res = a;
                repeat (n) r.res = {r.res[0], r.res[31:1]};
            end
            4: begin
                r.res = a;
                repeat (n) r.res = {r.res[30:0], r.res[31]};
            end
`ifdef ALU_PIPE_MUL_EN
            5: begin
                wide  = 64'(a) * 64'(b);
                r.res = wide[31:0];
                r.c   = (wide[63:32] != 0);
            end
`endif
            default: r.e = 1'b1;
        endcase
        if (op != 2 && !r.e) r.z = (r.res == 0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".res"}, bus.out_result, e.res);
        check({tag, ".carry"}, 32'(bus.out_carry), 32'(e.c));
        check({tag, ".zero"}, 32'(bus.out_zero), 32'(e.z));
        check({tag, ".gt"}, 32'(bus.out_gt), 32'(e.g));
        check({tag, ".err"}, 32'(bus.out_err), 32'(e.e));
    endtask

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'(op);
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    // One accepted op with the consumer ready; result checked one edge later.
    task automatic single(input string tag, input int op, input logic [31:0] a,
                          input logic [31:0] b);
        issue(op, a, b);
        #1;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_out(tag, model(op, a, b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        logic [31:0] a, b, a2, b2;
        exp_t e;

        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 32'(bus.out_valid), 32'd0);
        check("rst.res", bus.out_result, 32'd0);
        check("rst.flags", 32'({bus.out_carry, bus.out_zero, bus.out_gt, bus.out_err}), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);

        single("add_wrap", 0, 32'hFFFF_FFFF, 32'h1);
        single("sub_neg", 1, 32'd3, 32'd5);
        single("cmp_eq", 2, 32'd7, 32'd7);
        single("cmp_gt", 2, 32'd9, 32'd2);
        single("rotr1", 3, 32'h8000_0001, 32'd1);
        single("rotl0", 4, 32'h8000_0001, 32'd0);
        single("rotl33", 4, 32'h8000_0001, 32'd33);
        single("ill6", 6, 32'h1234_5678, 32'h1);
        single("ill7", 7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifndef ALU_PIPE_MUL_EN
        single("ill5", 5, 32'h0001_0000, 32'h0001_0000);
`endif

        // Idle cycle with consumer ready drains the result.
        @(posedge clk);
        #1;
        check("drain.valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back random stream: one result per edge.
        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 6));
            if (op >= 5) op = op + 1;
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
            if ($urandom_range(0, 3) == 0) a = b;
            issue(op, a, b);
            @(posedge clk);
            #1;
            check_out($sformatf("stream%0d", i), model(op, a, b));
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stream_end.valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: result held, new op stalled, then accepted on release.
        a  = $urandom;
        b  = $urandom;
        a2 = $urandom;
        b2 = 32'($urandom_range(0, 31));
        single("bp_first", 0, a, b);
        e = model(0, a, b);
        bus.out_ready = 1'b0;
        issue(3, a2, b2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_stall%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            check_out($sformatf("bp_hold%0d", i), e);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_out("bp_second", model(3, a2, b2));

`ifdef ALU_PIPE_MUL_EN
        for (int t = 0; t < 3; t++) begin
            a = (t == 0) ? 32'h0001_0000 : $urandom;
            b = (t == 0) ? 32'h0001_0000 : ((t == 1) ? 32'($urandom_range(0, 65535)) : $urandom);
            issue(5, a, b);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check($sformatf("mul%0d.busy_ready", t), 32'(bus.in_ready), 32'd0);
            for (int k = 1; k < W; k++) begin
                @(posedge clk);
                #1;
                if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                    check($sformatf("mul%0d.early_valid_c%0d", t, k), 32'(bus.out_valid), 32'd0);
                    check($sformatf("mul%0d.early_ready_c%0d", t, k), 32'(bus.in_ready), 32'd0);
                end
            end
            @(posedge clk);
            #1;
            check_out($sformatf("mul%0d", t), model(5, a, b));
        end

        // Reset in BUSY cycle 10 aborts the multiply.
        issue(5, $urandom, $urandom);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mul_abort.valid", 32'(bus.out_valid), 32'd0);
        check("mul_abort.in_ready", 32'(bus.in_ready), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("mul_abort.no_result", 32'(bus.out_valid), 32'd0);
        single("after_abort", 1, 32'd10, 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
